mulq64: RTL and testbench
=========================

# mulq64

Sequential signed multiply-accumulate unit: rebuilds a 64-bit signed value from a 32-bit unsigned factor, a 64-bit signed factor and a 32-bit unsigned addend (P = A×B ± C, addend sign follows A). It sits beside the spectrum datapath's long-division stage and performs the inverse operation, quotient × divisor + remainder, for normalisation and scale-back. It uses one radix-2 shift-add iteration per clock behind a Start/Done handshake.

## Interface
- No parameters; widths fixed (A 64, B 32, C 32, accumulator 96).
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  synchronous, active-low reset, sampled on CLK rising edge.
- Start  in  1  request; sampled only in IDLE.
- iMultiplicand  in  64  A, two's complement signed.
- iMultiplier  in  32  B, unsigned.
- iAddend  in  32  C, unsigned magnitude; present only with MULQ64_ADDEND_EN.
- Product  out  64  signed result, low 64 bits of ±(|A|×B + C); reset 0.
- Overflow  out  1  result not representable as signed 64-bit; reset 0.
- Busy  out  1  high in every state except IDLE; reset 0.
- Done  out  1  one-cycle pulse, Product/Overflow valid; reset 0.

## Operation
- States: IDLE → LOAD → RUN (32 cycles) → FIX → IDLE.
- IDLE: Start=1 latches A, B, C into internal registers, goes to LOAD. Start=0 stays.
- LOAD: Sign = A[63]; Mag = Sign ? (~A+1) : A as 64-bit unsigned (A = −2^63 gives Mag = 2^63, no error); Acc(96) = 0; Mcand(96) = {32'h0, Mag}; Mplier = B; Count = 0.
- RUN, per cycle: if Mplier[0], Acc += Mcand; Mcand <<= 1; Mplier >>= 1; Count += 1; leave after Count reaches 31 (32 iterations).
- FIX: Sum(97) = Acc + C; Res(97) = Sign ? −Sum : Sum; Product = Res[63:0]; Overflow = (Res[96:63] not all equal to Res[63]); Done = 1; state → IDLE.
- Product/Overflow change only in FIX; otherwise held.
- Done clears on the edge after FIX.
- Start while Busy: ignored, not queued. Operand changes after the latching edge: no effect.
- B = 0: Product = ±C. A = 0: Product = +C, with Sign = 0.
- Reset (RST_N=0 at any edge, including mid-RUN): state IDLE, Count 0, Acc 0, all outputs 0; the operation in progress is discarded with no Done.

## Timing
- Edge k samples Start in IDLE. LOAD runs at edge k+1, RUN at edges k+2..k+33, FIX at edge k+34.
- Done is high during the cycle after edge k+34. Latency is 34 clocks.
- Busy is high from after edge k through edge k+34, and low in the Done cycle.
- With Start held high, the next operation latches at edge k+35, giving a throughput of one result per 35 clocks.
- No combinational path from inputs to outputs.

## Configuration
- MULQ64_ADDEND_EN defined: iAddend port exists and C is added in FIX as specified.
- Undefined: iAddend port absent, C treated as 0, Product = ±(|A|×B). Latency is unchanged.

## Structure
- mulq64_pkg holds:
  - the state enum (IDLE, LOAD, RUN, FIX)
  - width constants: A_W=64, B_W=32, C_W=32, ACC_W=96
  - the iteration count constant N_ITER=32
- One sub-module, mulq64_signmag: combinational two's-complement conditional negate, parameterised width. It is used for the LOAD magnitude (64 bits) and the FIX sign restore (97 bits).
- The remainder of the design is the FSM and datapath in mulq64.

## Test plan
- A=100, B=7, C=3, Start at edge k → Done after edge k+34, Product=703 (0x2BF), Overflow=0.
- A=−100 (0xFFFF_FFFF_FFFF_FF9C), B=7, C=3 → Product=0xFFFF_FFFF_FFFF_FD41 (−703), Overflow=0.
- A=0x7FFF_FFFF_FFFF_FFFF, B=2, C=0 → Product=0xFFFF_FFFF_FFFF_FFFE, Overflow=1. A=0x8000_0000_0000_0000, B=1, C=0 → Product=0x8000_0000_0000_0000, Overflow=0.
- A=−1, B=0, C=5 → Product=0xFFFF_FFFF_FFFF_FFFB. Without MULQ64_ADDEND_EN, the same A/B → Product=0.
- Start pulses at cycles 5 and 20 after an accepted start → only one Done, at latency 34. Start held high → Done pulses exactly 35 cycles apart.
- RST_N low for one edge at cycle 10 of RUN → Busy/Done/Product/Overflow all 0, no Done afterwards. A new Start then completes normally with the correct result.

Source files
------------

// File: rtl/mulq64_pkg.sv
// mulq64_pkg: shared widths, iteration count and FSM state encoding for mulq64.
package mulq64_pkg;
    localparam int A_W    = 64;
    localparam int B_W    = 32;
    localparam int C_W    = 32;
    localparam int ACC_W  = 96;
    localparam int N_ITER = 32;
    localparam int CNT_W  = $clog2(N_ITER);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        FIX
    } state_t;
endpackage

// File: rtl/mulq64_signmag.sv
// mulq64_signmag: combinational two's-complement conditional negate of a W-bit value.
module mulq64_signmag #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);
    always_comb y = neg ? ~a + W'(1) : a;
endmodule

// File: rtl/mulq64.sv
// mulq64: sequential P = +/-(|A|*B + C), one radix-2 shift-add step per clock, Start/Done handshake.
// Define MULQ64_ADDEND_EN to add the iAddend port; otherwise C is 0.
module mulq64
    import mulq64_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [A_W-1:0]   iMultiplicand,
    input  logic [B_W-1:0]   iMultiplier,
`ifdef MULQ64_ADDEND_EN
    input  logic [C_W-1:0]   iAddend,
`endif
    output logic [A_W-1:0]   Product,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);
    state_t             state, state_nxt;
    logic [A_W-1:0]     a_r, mag;
    logic [B_W-1:0]     b_r, mplier;
    logic [C_W-1:0]     c_r, c_in;
    logic               sign;
    logic [ACC_W-1:0]   acc, mcand;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W:0]     sum, res;

`ifdef MULQ64_ADDEND_EN
    assign c_in = iAddend;
`else
    assign c_in = '0;
`endif

    mulq64_signmag #(.W(A_W)) u_mag (
        .a   (a_r),
        .neg (a_r[A_W-1]),
        .y   (mag)
    );

    assign sum = {1'b0, acc} + (ACC_W+1)'(c_r);

    mulq64_signmag #(.W(ACC_W+1)) u_res (
        .a   (sum),
        .neg (sign),
        .y   (res)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = Start ? LOAD : IDLE;
            LOAD:    state_nxt = RUN;
            RUN:     state_nxt = (cnt == CNT_W'(N_ITER-1)) ? FIX : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb Busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= '0;
            sign     <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            Product  <= '0;
            Overflow <= 1'b0;
            Done     <= 1'b0;
        end else begin
            if (state == IDLE && Start) begin
                a_r <= iMultiplicand;
                b_r <= iMultiplier;
                c_r <= c_in;
            end
            if (state == LOAD) begin
                sign   <= a_r[A_W-1];
                acc    <= '0;
                mcand  <= ACC_W'(mag);
                mplier <= b_r;
                cnt    <= '0;
            end
            if (state == RUN) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
            // Overflow when the bits above the sign position disagree with it
            if (state == FIX) begin
                Product  <= res[A_W-1:0];
                Overflow <= ~((&res[ACC_W:A_W-1]) | ~(|res[ACC_W:A_W-1]));
            end
            Done <= (state == FIX);
        end
    end
endmodule

// File: tb/tb_mulq64.sv
// tb_mulq64: directed self-checking bench for mulq64 (follows MULQ64_ADDEND_EN for expected values).
module tb_mulq64;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Start = 1'b0;
    logic [63:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] C = '0;
    logic [63:0] Product;
    logic        Overflow, Busy, Done;
    int          checks = 0;
    int          errors = 0;

`ifdef MULQ64_ADDEND_EN
    localparam bit ADD = 1'b1;
`else
    localparam bit ADD = 1'b0;
`endif

    mulq64 dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .Start         (Start),
        .iMultiplicand (A),
`ifdef MULQ64_ADDEND_EN
        .iAddend       (C),
`endif
        .iMultiplier   (B),
        .Product       (Product),
        .Overflow      (Overflow),
        .Busy          (Busy),
        .Done          (Done)
    );

    always #5 CLK = ~CLK;

    // Starts one operation from IDLE and waits (bounded) for Done.
    task automatic run_op(input logic [63:0] a, input logic [31:0] b, input logic [31:0] c,
                          output logic [63:0] p, output logic o, output int lat,
                          output logic busy_mid, output logic busy_done);
        logic got;
        @(negedge CLK);
        A = a; B = b; C = c; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        busy_mid = Busy;
        A = ~a; B = ~b; C = ~c;
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge CLK);
            lat++;
            #1 if (Done) got = 1'b1;
        end
        p = Product; o = Overflow; busy_done = Busy;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
        checks++; if (Product !== 64'h0) begin errors++; $display("FAIL reset_product got %h want 0", Product); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", Overflow); end
    endtask

    task automatic test_basic;
        logic [63:0] p; logic o, bm, bd; int lat;
        logic [63:0] exp_p = ADD ? 64'h2BF : 64'h2BC;
        run_op(64'd100, 32'd7, 32'd3, p, o, lat, bm, bd);
        checks++; if (lat !== 34) begin errors++; $display("FAIL basic_latency got %0d want 34", lat); end
        checks++; if (p !== exp_p) begin errors++; $display("FAIL basic_product got %h want %h", p, exp_p); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", o); end
        checks++; if (bm !== 1'b1) begin errors++; $display("FAIL basic_busy_mid got %b want 1", bm); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", bd); end
        @(posedge CLK); #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", Done); end
        checks++; if (Product !== exp_p) begin errors++; $display("FAIL basic_hold got %h want %h", Product, exp_p); end
    endtask

    task automatic test_negative;
        logic [63:0] p; logic o, bm, bd; int lat;
        logic [63:0] exp_p = ADD ? 64'hFFFF_FFFF_FFFF_FD41 : 64'hFFFF_FFFF_FFFF_FD44;
        run_op(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 32'd3, p, o, lat, bm, bd);
        checks++; if (p !== exp_p) begin errors++; $display("FAIL neg_product got %h want %h", p, exp_p); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL neg_ovf got %b want 0", o); end
    endtask

    task automatic test_overflow;
        logic [63:0] p; logic o, bm, bd; int lat;
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 32'd2, 32'd0, p, o, lat, bm, bd);
        checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL ovf_max_product got %h want fffffffffffffffe", p); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_max_flag got %b want 1", o); end
        run_op(64'h8000_0000_0000_0000, 32'd1, 32'd0, p, o, lat, bm, bd);
        checks++; if (p !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_min_product got %h want 8000000000000000", p); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL ovf_min_flag got %b want 0", o); end
    endtask

    task automatic test_zero_b;
        logic [63:0] p; logic o, bm, bd; int lat;
        logic [63:0] exp_p = ADD ? 64'hFFFF_FFFF_FFFF_FFFB : 64'h0;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 32'd5, p, o, lat, bm, bd);
        checks++; if (p !== exp_p) begin errors++; $display("FAIL zero_b_product got %h want %h", p, exp_p); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL zero_b_ovf got %b want 0", o); end
    endtask

    task automatic test_ignore_start;
        int n = 0, at = 0;
        @(negedge CLK);
        A = 64'd12; B = 32'd11; C = 32'd0; Start = 1'b1;
        @(posedge CLK);
        for (int i = 1; i <= 80; i++) begin
            @(negedge CLK);
            Start = (i == 5 || i == 20);
            A = 64'd1; B = 32'd1;
            @(posedge CLK);
            #1 if (Done) begin n++; at = i; end
        end
        Start = 1'b0;
        checks++; if (n !== 1) begin errors++; $display("FAIL ignore_count got %0d want 1", n); end
        checks++; if (at !== 34) begin errors++; $display("FAIL ignore_latency got %0d want 34", at); end
        checks++; if (Product !== 64'h84) begin errors++; $display("FAIL ignore_product got %h want 84", Product); end
    endtask

    task automatic test_back_to_back;
        int d1 = -1, d2 = -1;
        logic [63:0] p2 = '0;
        @(negedge CLK);
        A = 64'hFFFF_FFFF_FFFF_FFFE; B = 32'd3; C = 32'd0; Start = 1'b1;
        @(posedge CLK);
        for (int i = 1; i <= 120 && d2 < 0; i++) begin
            @(posedge CLK);
            #1 if (Done) begin
                if (d1 < 0) d1 = i;
                else begin d2 = i; p2 = Product; end
            end
        end
        @(negedge CLK) Start = 1'b0;
        checks++; if (d1 !== 34) begin errors++; $display("FAIL b2b_first got %0d want 34", d1); end
        checks++; if (d2 - d1 !== 35) begin errors++; $display("FAIL b2b_spacing got %0d want 35", d2 - d1); end
        checks++; if (p2 !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL b2b_product got %h want fffffffffffffffa", p2); end
        repeat (40) @(posedge CLK);
    endtask

    task automatic test_midreset;
        logic [63:0] p; logic o, bm, bd; int lat, n = 0;
        logic [63:0] exp_p = ADD ? 64'd16 : 64'd15;
        @(negedge CLK);
        A = 64'd3; B = 32'd5; C = 32'd1; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (10) @(posedge CLK);
        #1 RST_N = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", Done); end
        checks++; if (Product !== 64'h0) begin errors++; $display("FAIL midrst_product got %h want 0", Product); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", Overflow); end
        repeat (50) begin
            @(posedge CLK);
            #1 if (Done) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL midrst_stray_done got %0d want 0", n); end
        run_op(64'd3, 32'd5, 32'd1, p, o, lat, bm, bd);
        checks++; if (lat !== 34) begin errors++; $display("FAIL midrst_new_latency got %0d want 34", lat); end
        checks++; if (p !== exp_p) begin errors++; $display("FAIL midrst_new_product got %h want %h", p, exp_p); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_zero_b();
        test_ignore_start();
        test_back_to_back();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
